channel_frame_builder: RTL and testbench

Producer side of the parallel channel bundle consumed by the median filter. Accepts one channel sample per handshake from a serial sample stream and packs `CHANNELS` consecutive samples into a frame. It presents each frame as a packed `[CHANNELS-1:0][BITS_PER_CHANNEL-1:0]` vector with a valid/ready handshake. Internal fill and output registers allow continuous streaming at one sample per cycle.

---
 rtl/channel_frame_builder.sv | 91 +++++++++
 tb/tb_channel_frame_builder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/channel_frame_builder.sv
// channel_frame_builder: packs CHANNELS consecutive serial samples into one parallel frame
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready, in_data serial sample handshake and value
//   in_first                   channel-0 marker, honoured only with FRAME_SYNC_EN
//   frame_valid/frame_ready    frame handshake
//   frame_data                 element i holds channel i
//   fill_idx                   slot the next accepted sample fills
//   sync_err                   one-cycle resync pulse (FRAME_SYNC_EN), else 0
// Optional feature: define FRAME_SYNC_EN to resynchronise on in_first.
module channel_frame_builder #(
  parameter int CHANNELS = 8,
  parameter int BITS_PER_CHANNEL = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic [BITS_PER_CHANNEL-1:0]               in_data,
  input  logic                                      in_first,
  output logic                                      in_ready,
  output logic                                      frame_valid,
  input  logic                                      frame_ready,
  output logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] frame_data,
  output logic [$clog2(CHANNELS)-1:0]               fill_idx,
  output logic                                      sync_err
);
  localparam int IW = $clog2(CHANNELS);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHANNELS-1:0][BITS_PER_CHANNEL-1:0] fill_q, fill_d, frame_q, frame_d;
  logic fvalid_q, fvalid_d;
  logic acc, slot_free, resync;
  assign in_ready = state_q == FILL;
  assign acc = in_valid && in_ready;
  assign slot_free = !fvalid_q || frame_ready;
  assign frame_valid = fvalid_q;
  assign frame_data = frame_q;
  assign fill_idx = idx_q;
`ifdef FRAME_SYNC_EN
  logic serr_q;
  assign resync = acc && in_first && idx_q != '0;
  assign sync_err = serr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) serr_q <= 1'b0;
    else serr_q <= resync;
`else
  assign resync = 1'b0;
  // in_first is folded in only so the port counts as read; the result is 0.
  assign sync_err = 1'b0 & in_first;
`endif
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fill_d = fill_q;
    frame_d = frame_q;
    fvalid_d = fvalid_q && !frame_ready;
    if (acc) begin
      // A resync restarts the frame: the marked sample becomes channel 0.
      fill_d[resync ? IW'(0) : idx_q] = in_data;
      idx_d = resync ? IW'(1) : idx_q + IW'(1);
      if (!resync && idx_q == IW'(CHANNELS - 1)) begin
        if (slot_free) begin
          frame_d = fill_d;
          fvalid_d = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end
    end
    if (state_q == HOLD && slot_free) begin
      frame_d = fill_q;
      fvalid_d = 1'b1;
      state_d = FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      idx_q <= '0;
      fill_q <= '0;
      frame_q <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fill_q <= fill_d;
      frame_q <= frame_d;
      fvalid_q <= fvalid_d;
    end
endmodule

// File: tb/tb_channel_frame_builder.sv
// tb_channel_frame_builder: scoreboard bench for channel_frame_builder
module tb_channel_frame_builder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_first = 1'b0;
  logic in_ready;
  logic frame_valid;
  logic frame_ready = 1'b0;
  logic [7:0][7:0] frame_data;
  logic [2:0] fill_idx;
  logic sync_err;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int vcount = 0;
  int scount = 0;
  logic held = 1'b0;
  logic [7:0][7:0] hdata = '0;
  logic [7:0][7:0] q[$];
  logic [7:0][7:0] ef;

  channel_frame_builder #(.CHANNELS(8), .BITS_PER_CHANNEL(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_first(in_first),
    .in_ready(in_ready), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .fill_idx(fill_idx), .sync_err(sync_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0][7:0] mk(input logic [7:0] base);
    logic [7:0][7:0] f;
    for (int i = 0; i < 8; i++) f[i] = base + 8'(i);
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic f);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_first = f;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n > 0) stalls++;
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_valid", 64'(frame_valid), 64'd1);
        chk("hold_data", frame_data, hdata);
      end
      if (frame_valid) vcount++;
      if (sync_err) scount++;
      if (frame_valid && frame_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got %h expected none", frame_data);
        end else chk("frame", frame_data, q.pop_front());
      end
      held = frame_valid && !frame_ready;
      hdata = frame_data;
    end
  end

  initial begin
    cycles(2);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_data", frame_data, 64'd0);
    chk("rst_fill_idx", 64'(fill_idx), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
    rst_n = 1'b1;
    cycles(1);
    // single frame latency
    frame_ready = 1'b1;
    q.push_back(mk(8'h10));
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
    chk("t1_valid", 64'(frame_valid), 64'd1);
    chk("t1_ch0", 64'(frame_data[0]), 64'h10);
    chk("t1_ch7", 64'(frame_data[7]), 64'h17);
    chk("t1_fill_idx", 64'(fill_idx), 64'd0);
    cycles(2);
    // sustained streaming
    vcount = 0;
    stalls = 0;
    for (int f = 0; f < 3; f++) q.push_back(mk(8'(f * 8)));
    for (int i = 0; i < 24; i++) send(8'(i), 1'b0);
    cycles(2);
    chk("t2_stalls", 64'(stalls), 64'd0);
    chk("t2_valid_cycles", 64'(vcount), 64'd3);
    // backpressure
    frame_ready = 1'b0;
    stalls = 0;
    q.push_back(mk(8'h20));
    q.push_back(mk(8'h28));
    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0);
    chk("t3_stalls", 64'(stalls), 64'd0);
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    chk("t3_frame_a", frame_data, mk(8'h20));
    cycles(3);
    chk("t3_still_held", 64'(in_ready), 64'd0);
    frame_ready = 1'b1;
    cycles(1);
    frame_ready = 1'b0;
    chk("t3_valid_kept", 64'(frame_valid), 64'd1);
    chk("t3_in_ready_back", 64'(in_ready), 64'd1);
    chk("t3_frame_b", frame_data, mk(8'h28));
    cycles(2);
    frame_ready = 1'b1;
    cycles(2);
    chk("t3_drained", 64'(frame_valid), 64'd0);
    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 1'b0);
    chk("t4_fill_idx5", 64'(fill_idx), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_frame_valid", 64'(frame_valid), 64'd0);
    chk("t4_frame_data", frame_data, 64'd0);
    chk("t4_fill_idx", 64'(fill_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    q.push_back(mk(8'h40));
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 1'b0);
    chk("t4_frame", frame_data, mk(8'h40));
    cycles(2);
    // in_first resynchronisation
    scount = 0;
`ifdef FRAME_SYNC_EN
    ef[0] = 8'hAA;
    for (int i = 1; i < 8; i++) ef[i] = 8'h52 + 8'(i);
`else
    ef = {8'h56, 8'h55, 8'h54, 8'h53, 8'hAA, 8'h52, 8'h51, 8'h50};
`endif
    q.push_back(ef);
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b0);
    send(8'hAA, 1'b1);
`ifdef FRAME_SYNC_EN
    chk("t5_sync_pulse", 64'(sync_err), 64'd1);
`else
    chk("t5_sync_zero", 64'(sync_err), 64'd0);
`endif
    for (int i = 0; i < 7; i++) send(8'h53 + 8'(i), 1'b0);
    cycles(3);
`ifdef FRAME_SYNC_EN
    chk("t5_sync_count", 64'(scount), 64'd1);
    chk("t5_fill_idx", 64'(fill_idx), 64'd0);
`else
    chk("t5_sync_count", 64'(scount), 64'd0);
    chk("t5_fill_idx", 64'(fill_idx), 64'd3);
`endif
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
